// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and byte sequencer that shares one uart_byte_tx
// between NUM_REQ requesters, with packet lock, gap timer and watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [2:0]           cfg_baud,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err_timeout,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 tx_send_en,
  output logic [2:0]           tx_baud_set,
  input  logic                 tx_done,
  input  logic                 tx_busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYCLES > 2) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 2) ?
                      $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PW-1:0] PTR_MAX  = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GAP
  } state_t;

  state_t               r_state, w_state;
  logic [PW-1:0]        r_ptr, w_ptr;
  logic [PW-1:0]        r_g, w_g;
  logic                 r_lock, w_lock;
  logic [CW-1:0]        r_cnt, w_cnt;
  logic [GW-1:0]        r_gcnt, w_gcnt;
  logic [NUM_REQ-1:0]   r_ack, w_ack;
  logic [NUM_REQ-1:0]   r_done, w_done;
  logic                 r_err, w_err;
  logic                 r_busy, w_busy;
  logic [7:0]           r_data, w_data;
  logic                 r_send, w_send;
  logic [2:0]           r_baud, w_baud;

  logic [PW:0]          w_pick;
  logic                 w_elig;
  logic [PW-1:0]        w_gsel;

  // First set bit of v at or above p, wrapping; MSB flags a hit.
  function automatic logic [PW:0] f_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [PW-1:0]      p
  );
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (v[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] f_inc(
    input logic [PW-1:0] g
  );
    return (g == PTR_MAX) ? '0 : g + PW'(1);
  endfunction

  assign w_pick = f_pick(req, r_ptr);
  assign w_elig = r_lock ? req[r_g] : w_pick[PW];
  assign w_gsel = r_lock ? r_g : w_pick[PW-1:0];

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_g     = r_g;
    w_lock  = r_lock;
    w_cnt   = r_cnt;
    w_gcnt  = r_gcnt;
    w_ack   = '0;
    w_done  = '0;
    w_err   = 1'b0;
    w_send  = 1'b0;
    w_data  = r_data;
    w_baud  = r_baud;
    unique case (r_state)
      S_IDLE: begin
        if (!r_lock) w_baud = cfg_baud;
        if (w_elig && !tx_busy) begin
          w_g     = w_gsel;
          w_ack   = NUM_REQ'(1) << w_gsel;
          w_send  = 1'b1;
          w_data  = req_data[8*w_gsel +: 8];
          w_lock  = ~req_last[w_gsel];
          w_state = S_SEND;
        end
      end
      S_SEND: begin
        w_cnt   = '0;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          w_done  = NUM_REQ'(1) << r_g;
          w_cnt   = '0;
          w_gcnt  = '0;
          if (!r_lock) w_ptr = f_inc(r_g);
          w_state = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else if (r_cnt == TO_LAST) begin
          // Abort: drop the packet and move on.
          w_err   = 1'b1;
          w_lock  = 1'b0;
          w_ptr   = f_inc(r_g);
          w_cnt   = '0;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (r_gcnt == GAP_LAST) w_state = S_IDLE;
        else                    w_gcnt  = r_gcnt + GW'(1);
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE) || w_lock;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_g     <= '0;
      r_lock  <= 1'b0;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_ack   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= '0;
      r_send  <= 1'b0;
      r_baud  <= 3'b000;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_g     <= w_g;
      r_lock  <= w_lock;
      r_cnt   <= w_cnt;
      r_gcnt  <= w_gcnt;
      r_ack   <= w_ack;
      r_done  <= w_done;
      r_err   <= w_err;
      r_busy  <= w_busy;
      r_data  <= w_data;
      r_send  <= w_send;
      r_baud  <= w_baud;
    end
  end

  assign ack         = r_ack;
  assign done        = r_done;
  assign err_timeout = r_err;
  assign busy        = r_busy;
  assign tx_data     = r_data;
  assign tx_send_en  = r_send;
  assign tx_baud_set = r_baud;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one uart_byte_tx instance between NUM_REQ byte requesters.
- Grants one byte at a time and drives the transmitter's send_en and data_byte for that byte. Then waits for tx_done, inserts a configurable inter-byte gap, and re-arbitrates.
- Supports packet lock: a requester keeps the transmitter until it supplies a byte marked last.
- Includes a tx_done watchdog and a baud-rate config latch. Sits between system requesters and uart_byte_tx.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle clk cycles after tx_done before the next grant (0 = none).
- TIMEOUT_CYCLES, 1_000_000, max clk cycles in WAIT before abort (must exceed 11 bit times at slowest baud).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester byte request; held high until its ack.
- req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i].
- req_last  in  NUM_REQ  byte for requester i ends its packet.
- cfg_baud  in  3  baud selection to forward to the transmitter.
- ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- done  out  NUM_REQ  one-cycle pulse: byte of requester i fully sent.
- err_timeout  out  1  one-cycle pulse on watchdog abort.
- busy  out  1  high in any state other than IDLE, or while locked.
- tx_data  out  8  to uart_byte_tx data_byte.
- tx_send_en  out  1  to uart_byte_tx send_en; one-cycle pulse.
- tx_baud_set  out  3  to uart_byte_tx baud_set.
- tx_done  in  1  from uart_byte_tx tx_done.
- tx_busy  in  1  from uart_byte_tx uart_state.

Behaviour:
- Reset values: all outputs 0 except tx_baud_set=3'b000. State=IDLE, rr pointer=0, lock=0, counters=0. Reset mid-frame abandons the byte with no done or err.
- All outputs are registered.
- State machine has four states: IDLE, SEND, WAIT, GAP.
- IDLE, grant selection:
  - If lock=1, only requester g is eligible.
  - Otherwise, search from the rr pointer upward with wrap, and take the first i with req[i]=1.
  - A grant is issued only if tx_busy=0.
  - If an eligible requester exists, the next cycle asserts ack[g]=1 and tx_send_en=1, with tx_data = req_data[g] latched. State goes to SEND.
  - Latency from req high (idle, unlocked, pointer at i) to ack/tx_send_en is 1 cycle.
- IDLE, baud latch: when lock=0, tx_baud_set <= cfg_baud every cycle. It is frozen in all other states and while locked.
- Lock update on grant: lock <= ~req_last[g].
- SEND: lasts 1 cycle (send_en pulse already out). Then WAIT. tx_data holds stable until the next grant.
- WAIT:
  - Count cycles; tx_done is ignored outside WAIT.
  - On tx_done=1: pulse done[g] next cycle and reset the timeout counter. Go to GAP if GAP_CYCLES>0, else IDLE.
  - If the count reaches TIMEOUT_CYCLES-1 without tx_done: pulse err_timeout, clear lock, advance the rr pointer, go to IDLE. No done pulse.
- GAP: stay exactly GAP_CYCLES cycles, then IDLE.
- rr pointer:
  - On leaving WAIT with lock=0 (packet or single byte finished), pointer <= (g+1) mod NUM_REQ.
  - While locked, the pointer is unchanged.
- Locked with req[g]=0: remain in IDLE. Other requesters starve until g sends a byte with req_last=1; busy stays high.
- Simultaneous requests: the rr order decides. Only one ack per grant.
- A requester dropping req before ack: no grant, no error.
- req_data is sampled only in the grant cycle. The requester may change it after ack.

Test Plan:
- Single request: req=4'b0001, data 8'hA5, last=1 -> ack[0] 1 cycle later with tx_send_en. tx_data=8'hA5. done[0] 1 cycle after tx_done, busy low after GAP_CYCLES.
- Round robin: req=4'b1111 held, all last=1, tx model returns tx_done 100 cycles after send_en -> grant order 0,1,2,3,0. Each ack followed by done before the next ack.
- Packet lock: requester 2 sends 3 bytes (last=0,0,1) while req[0] is held -> acks 2,2,2, then 0. Requester 0 is never acked mid-packet.
- Timeout: tx_done held 0, TIMEOUT_CYCLES=200 -> err_timeout pulses once ~200 cycles after send_en. No done, lock cleared, next requester granted.
- Baud latch: change cfg_baud 3'b000->3'b011 mid-WAIT -> tx_baud_set stays 000 until IDLE, then 011.
- Reset mid-WAIT: assert reset_n=0 -> all outputs 0 immediately, tx_baud_set=000. No done or err after release.
